// File: rtl/shift_register_latched.sv
// Serial shift-out driver for chained 74HC595-style registers: shifts a WIDTH-bit
// word on o_serial_data/o_serial_clk at the i_clk_stb rate, then pulses o_serial_latch.
module shift_register_latched #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int LATCH_STB = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clk_stb,
   input  logic             i_start_stb,
   input  logic [WIDTH-1:0] i_parallel_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_serial_data,
   output logic             o_serial_clk,
   output logic             o_serial_latch
);

   localparam int BCW = $clog2(WIDTH);
   localparam int LCW = (LATCH_STB > 1) ? $clog2(LATCH_STB) : 1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [LCW-1:0] LAT_LAST = LCW'(LATCH_STB - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HOLD,
      ST_LATCH
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [BCW-1:0]   r_bit_cnt;
   logic [LCW-1:0]   r_lat_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_sclk;
   logic             r_latch;
   logic [WIDTH-1:0] w_load;

   // The word is stored in send order so the outgoing bit is always r_shift[WIDTH-1].
   always_comb begin
      // NOTE: default first so every path assigns w_load and no latch is inferred.
      w_load = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_load[i] = MSB_FIRST ? i_parallel_data[i] : i_parallel_data[WIDTH-1-i];
      end
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_lat_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sclk    <= 1'b0;
         r_latch   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A start in the o_done cycle is dropped, not queued.
               if (i_start_stb && !r_done) begin
                  r_shift   <= w_load;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (i_clk_stb) begin
                  r_sclk  <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (i_clk_stb) begin
                  r_sclk <= 1'b0;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_shift   <= '0;
                     r_latch   <= 1'b1;
                     r_lat_cnt <= '0;
                     r_state   <= ST_LATCH;
                  end else begin
                     r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                     r_state   <= ST_SETUP;
                  end
               end
            end
            ST_LATCH: begin
               if (i_clk_stb) begin
                  if (r_lat_cnt == LAT_LAST) begin
                     r_lat_cnt <= '0;
                     r_latch   <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_lat_cnt <= r_lat_cnt + LCW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_serial_data  = r_shift[WIDTH-1];
   assign o_serial_clk   = r_sclk;
   assign o_serial_latch = r_latch;

   a_latch_vs_clk : assert property (@(posedge i_clk) disable iff (i_reset)
      !(r_latch && r_sclk));
   a_done_idle : assert property (@(posedge i_clk) disable iff (i_reset)
      r_done |-> !r_busy);

endmodule

// File: tb/tb_shift_register_latched.sv
// Bench for shift_register_latched: three instances (8/MSB/1, 8/LSB/1, 16/MSB/3) checked
// every cycle against a strobe-count model, plus directed literal checks per scenario.
`timescale 1ns/1ps
module tb_shift_register_latched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic [2:0]  start = 3'b000;
   logic [15:0] pdata [3];
   wire  [2:0]  busy, done, sdata, sclk, slatch;

   int stb_period = 4;
   int stb_cnt    = 0;
   int stb_total  = 0;
   int n_checks   = 0;
   int n_errors   = 0;
   bit chk_en     = 1'b0;

   always #5 clk = ~clk;

   shift_register_latched #(.WIDTH(8), .MSB_FIRST(1'b1), .LATCH_STB(1)) u_a (
      .i_clk(clk), .i_reset(rst), .i_clk_stb(stb), .i_start_stb(start[0]),
      .i_parallel_data(pdata[0][7:0]), .o_busy(busy[0]), .o_done(done[0]),
      .o_serial_data(sdata[0]), .o_serial_clk(sclk[0]), .o_serial_latch(slatch[0]));

   shift_register_latched #(.WIDTH(8), .MSB_FIRST(1'b0), .LATCH_STB(1)) u_b (
      .i_clk(clk), .i_reset(rst), .i_clk_stb(stb), .i_start_stb(start[1]),
      .i_parallel_data(pdata[1][7:0]), .o_busy(busy[1]), .o_done(done[1]),
      .o_serial_data(sdata[1]), .o_serial_clk(sclk[1]), .o_serial_latch(slatch[1]));

   shift_register_latched #(.WIDTH(16), .MSB_FIRST(1'b1), .LATCH_STB(3)) u_c (
      .i_clk(clk), .i_reset(rst), .i_clk_stb(stb), .i_start_stb(start[2]),
      .i_parallel_data(pdata[2]), .o_busy(busy[2]), .o_done(done[2]),
      .o_serial_data(sdata[2]), .o_serial_clk(sclk[2]), .o_serial_latch(slatch[2]));

   function automatic int p_w(int i);
      return (i == 2) ? 16 : 8;
   endfunction
   function automatic int p_l(int i);
      return (i == 2) ? 3 : 1;
   endfunction
   function automatic bit p_msb(int i);
      return (i != 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Strobe source: one cycle high every stb_period cycles (always high when 1).
   always @(negedge clk) begin
      if (stb_cnt >= stb_period - 1) stb_cnt = 0;
      else stb_cnt++;
      stb = (stb_cnt == 0);
   end

   always @(posedge clk) if (stb) stb_total++;

   // Transfer model: k counts strobes since the accepted start; a transfer lasts 2W+L.
   bit          m_act  [3];
   int          m_k    [3];
   logic [15:0] m_word [3];
   bit          m_done [3];

   always @(posedge clk) begin
      bit was_done;
      for (int i = 0; i < 3; i++) begin
         was_done  = m_done[i];
         m_done[i] = 1'b0;
         if (rst) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
         end else if (m_act[i]) begin
            if (stb) begin
               m_k[i]++;
               if (m_k[i] == 2 * p_w(i) + p_l(i)) begin
                  m_act[i]  = 1'b0;
                  m_done[i] = 1'b1;
               end
            end
         end else if (start[i] && !was_done) begin
            m_act[i]  = 1'b1;
            m_k[i]    = 0;
            m_word[i] = pdata[i];
         end
      end
   end

   function automatic logic [4:0] exp_vec(int i);
      int w = p_w(i);
      int k = m_k[i];
      logic d = 1'b0;
      logic c = 1'b0;
      logic l = 1'b0;
      if (m_act[i]) begin
         if (k < 2 * w) begin
            c = (k % 2) == 1;
            d = p_msb(i) ? m_word[i][w-1-k/2] : m_word[i][k/2];
         end else begin
            l = 1'b1;
         end
      end
      return {m_act[i], m_done[i], d, c, l};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("outs%0d {busy,done,data,clk,latch}", i),
                  {busy[i], done[i], sdata[i], sclk[i], slatch[i]}, exp_vec(i));
         end
      end
   end

   // Device-side monitor: shift register clocked by o_serial_clk rising edges.
   logic [15:0] cap [3];
   int nbits [3], pulses [3], latch_cyc [3], busy_cyc [3], dones [3], stb0 [3], span [3];
   bit p_busy [3], p_sclk [3];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy[i] == 1'b1 && !p_busy[i]) begin
            cap[i] = '0; nbits[i] = 0; pulses[i] = 0; latch_cyc[i] = 0;
            busy_cyc[i] = 0; dones[i] = 0; stb0[i] = stb_total; span[i] = -1;
         end
         if (sclk[i] == 1'b1 && !p_sclk[i]) begin
            pulses[i]++;
            if (p_msb(i)) cap[i] = {cap[i][14:0], sdata[i]};
            else cap[i][nbits[i]] = sdata[i];
            nbits[i]++;
         end
         if (slatch[i] == 1'b1) latch_cyc[i]++;
         if (busy[i] == 1'b1) busy_cyc[i]++;
         if (done[i] == 1'b1) begin
            dones[i]++;
            span[i] = stb_total - stb0[i];
         end
         p_busy[i] = (busy[i] == 1'b1);
         p_sclk[i] = (sclk[i] == 1'b1);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_txn(input int idx, input logic [15:0] d);
      pdata[idx] = d;
      start[idx] = 1'b1;
      step();
      start[idx] = 1'b0;
      pdata[idx] = ~d;
   endtask

   task automatic wait_done(input int idx, input int budget);
      int n = 0;
      while (done[idx] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check($sformatf("done%0d within budget", idx), done[idx], 1);
   endtask

   task automatic wait_pulse(input int idx, input int np, input int budget);
      int n = 0;
      while (!(pulses[idx] == np && sclk[idx] == 1'b1) && n < budget) begin
         step();
         n++;
      end
      check($sformatf("inst%0d reached pulse %0d", idx, np), pulses[idx], np);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) pdata[i] = '0;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset outs%0d", i),
               {busy[i], done[i], sdata[i], sclk[i], slatch[i]}, 0);
      end
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (3) step();

      // MSB-first 0xA5, strobe every 4 cycles
      start_txn(0, 16'h00A5);
      wait_done(0, 400);
      repeat (2) step();
      check("t1 captured word", cap[0], 16'h00A5);
      check("t1 clk pulses", pulses[0], 8);
      check("t1 latch cycles", latch_cyc[0], 4);
      check("t1 strobes start->done", span[0], 17);
      check("t1 done pulses", dones[0], 1);

      // LSB-first 0xC4
      start_txn(1, 16'h00C4);
      wait_done(1, 400);
      repeat (2) step();
      check("t2 captured word", cap[1], 16'h00C4);
      check("t2 clk pulses", pulses[1], 8);

      // starts while busy and in the o_done cycle are dropped
      start_txn(0, 16'h005A);
      wait_pulse(0, 4, 400);
      start_txn(0, 16'h00FF);
      wait_done(0, 400);
      pdata[0] = 16'h00FF;
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      repeat (10) step();
      check("t3 captured word", cap[0], 16'h005A);
      check("t3 clk pulses", pulses[0], 8);
      check("t3 done pulses", dones[0], 1);
      check("t3 busy after", busy[0], 0);

      // reset during HOLD of bit 4
      start_txn(0, 16'h003C);
      wait_pulse(0, 5, 400);
      rst = 1'b1;
      step();
      check("t4 busy after reset", busy[0], 0);
      check("t4 sclk after reset", sclk[0], 0);
      check("t4 latch after reset", slatch[0], 0);
      check("t4 done after reset", done[0], 0);
      rst = 1'b0;
      repeat (8) step();
      check("t4 no done for abandoned", dones[0], 0);
      start_txn(0, 16'h000F);
      wait_done(0, 400);
      repeat (2) step();
      check("t4 captured word", cap[0], 16'h000F);
      check("t4 clk pulses", pulses[0], 8);

      // 16-bit, LATCH_STB=3, start coincident with a strobe
      stb_period = 2;
      repeat (3) step();
      while (stb !== 1'b1) step();
      start_txn(2, 16'h1234);
      wait_done(2, 400);
      repeat (2) step();
      check("t5 captured word", cap[2], 16'h1234);
      check("t5 clk pulses", pulses[2], 16);
      check("t5 latch cycles", latch_cyc[2], 6);
      check("t5 strobes start->done", span[2], 35);
      check("t5 done pulses", dones[2], 1);

      // strobe tied high
      stb_period = 1;
      repeat (3) step();
      start_txn(0, 16'h0080);
      wait_done(0, 100);
      repeat (2) step();
      check("t6 busy cycles", busy_cyc[0], 17);
      check("t6 captured word", cap[0], 16'h0080);
      check("t6 clk pulses", pulses[0], 8);
      check("t6 strobes start->done", span[0], 17);

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
